// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/ID operand forwarding selects, load scoreboard with load-use interlock and a
// consecutive-stall watchdog. Defining HAZARD_PERF_EN adds the stall/load-use performance counters.
module fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int NUM_SRC   = 2,
    parameter int STALL_TMO = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic                   id_is_load,
    input  logic                   id_reg_write,
    input  logic [AW-1:0]          id_rd_addr,
    input  logic [NUM_SRC*AW-1:0]  ex_src_addr,
    input  logic                   ex_reg_write,
    input  logic                   ex_is_load,
    input  logic [AW-1:0]          ex_rd_addr,
    input  logic                   mem_reg_write,
    input  logic                   mem_is_load,
    input  logic [AW-1:0]          mem_rd_addr,
    input  logic                   wb_reg_write,
    input  logic                   wb_is_load,
    input  logic [AW-1:0]          wb_rd_addr,
    output logic [2*NUM_SRC-1:0]   fwd_ex_sel,
    output logic [2*NUM_SRC-1:0]   fwd_id_sel,
    output logic                   stall_id,
    output logic                   flush_ex,
    output logic                   sb_busy,
    output logic                   hazard_err,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_lu_cnt
);

    localparam int NREG   = 1 << AW;
    localparam int CW_RAW = $clog2(STALL_TMO + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    localparam logic [CW-1:0]   TMO_LAST = CW'(STALL_TMO - 1);
    localparam logic [CW-1:0]   TMO_SAT  = CW'(STALL_TMO);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   REG_ZERO = {AW{1'b0}};
    localparam logic [NREG-1:0] BIT0     = {{(NREG-1){1'b0}}, 1'b1};

    logic [2*NUM_SRC-1:0] fwd_ex_sel_s;
    logic [2*NUM_SRC-1:0] fwd_id_sel_s;
    logic                 wb_clr_s;
    logic                 dep_s;
    logic                 stall_s;
    logic                 issue_s;
    logic [NREG-1:0]      set_vec_s;
    logic [NREG-1:0]      clr_vec_s;
    logic [NREG-1:0]      sb_d;
    logic [NREG-1:0]      sb_q;
    logic [CW-1:0]        wd_cnt_d;
    logic [CW-1:0]        wd_cnt_q;
    logic                 hazard_err_d;
    logic                 hazard_err_q;

    // EX operands only see MEM/WB; a load in MEM has no data yet, so it never forwards.
    function automatic logic [1:0] ex_sel_f(input logic [AW-1:0] a);
        logic [1:0] sel;
        if (a == REG_ZERO) begin
            sel = 2'b00;
        end else if (mem_reg_write && !mem_is_load && (mem_rd_addr == a)) begin
            sel = 2'b10;
        end else if (wb_reg_write && (wb_rd_addr == a)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // ID operands may take the EX ALU result, but never a load still in flight.
    function automatic logic [1:0] id_sel_f(input logic [AW-1:0] a, input logic used);
        logic [1:0] sel;
        if (!used || (a == REG_ZERO)) begin
            sel = 2'b00;
        end else if (ex_reg_write && !ex_is_load && (ex_rd_addr == a)) begin
            sel = 2'b11;
        end else if (mem_reg_write && !mem_is_load && (mem_rd_addr == a)) begin
            sel = 2'b10;
        end else if (wb_reg_write && (wb_rd_addr == a)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Per-operand forwarding selects for both stages.
    always_comb begin
        fwd_ex_sel_s = '0;
        fwd_id_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_ex_sel_s[2*i +: 2] = ex_sel_f(ex_src_addr[i*AW +: AW]);
            fwd_id_sel_s[2*i +: 2] = id_sel_f(id_src_addr[i*AW +: AW], id_src_used[i]);
        end
    end

    // Load-use interlock; a register whose load completes this cycle is bypassed via WB.
    always_comb begin
        wb_clr_s = wb_reg_write & wb_is_load;
        dep_s    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dep_s = dep_s | (id_src_used[i]
                             & (id_src_addr[i*AW +: AW] != REG_ZERO)
                             & sb_q[id_src_addr[i*AW +: AW]]
                             & ~(wb_clr_s & (wb_rd_addr == id_src_addr[i*AW +: AW])));
        end
        stall_s = id_valid & dep_s;
        issue_s = id_valid & ~stall_s & id_is_load & id_reg_write & (id_rd_addr != REG_ZERO);
    end

    // Scoreboard next state: clear applied first so a same-register issue keeps the bit set.
    always_comb begin
        set_vec_s = issue_s  ? (BIT0 << id_rd_addr) : {NREG{1'b0}};
        clr_vec_s = wb_clr_s ? (BIT0 << wb_rd_addr) : {NREG{1'b0}};
        sb_d      = (sb_q & ~clr_vec_s) | set_vec_s;
    end

    // Watchdog: saturating run-length of stall cycles; the flag latches on the timeout cycle.
    always_comb begin
        if (!stall_s) begin
            wd_cnt_d = {CW{1'b0}};
        end else if (wd_cnt_q == TMO_SAT) begin
            wd_cnt_d = wd_cnt_q;
        end else begin
            wd_cnt_d = wd_cnt_q + CNT_ONE;
        end
        hazard_err_d = hazard_err_q | (stall_s & (wd_cnt_q == TMO_LAST));
    end

    // Scoreboard and watchdog state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q         <= {NREG{1'b0}};
            wd_cnt_q     <= {CW{1'b0}};
            hazard_err_q <= 1'b0;
        end else begin
            sb_q         <= sb_d;
            wd_cnt_q     <= wd_cnt_d;
            hazard_err_q <= hazard_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_lu_d;
    logic [31:0] perf_lu_q;
    logic        stall_prev_d;
    logic        stall_prev_q;

    // Stall-cycle total and load-use event count (rising edges of the stall).
    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_s};
        perf_lu_d    = perf_lu_q + {31'd0, stall_s & ~stall_prev_q};
        stall_prev_d = stall_s;
    end

    // Performance counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_lu_q    <= 32'd0;
            stall_prev_q <= 1'b0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lu_q    <= perf_lu_d;
            stall_prev_q <= stall_prev_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_lu_cnt    = perf_lu_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_lu_cnt    = 32'd0;
`endif

    assign fwd_ex_sel = fwd_ex_sel_s;
    assign fwd_id_sel = fwd_id_sel_s;
    assign stall_id   = stall_s;
    assign flush_ex   = stall_s;
    assign sb_busy    = |sb_q;
    assign hazard_err = hazard_err_q;

endmodule
